// File: rtl/decoder_strobe_seq_pkg.sv
// Shared types and helpers for the registered strobe decoder.
// Holds the FSM state encoding, mode codes, a one-hot helper and counter sizing.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_PULSE = 2'b10,
    ST_SCAN  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // Widest select the helper supports; callers truncate to their own OUT_W.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/decoder_strobe_seq_onehot_decode.sv
// Combinational SEL_W -> 2**SEL_W one-hot decode with enable; zero latency,
// no flow control (pure function of its inputs).
module onehot_decode
  import decoder_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      idx,
  output logic [2**SEL_W-1:0]   y
);

  localparam int OUT_W = 2 ** SEL_W;

  assign y = en ? OUT_W'(onehot(MAX_SEL_W'(idx))) : '0;

endmodule

// File: rtl/decoder_strobe_seq.sv
// Registered one-hot line decoder with level/pulse/scan modes; outputs follow an accept by 1 cycle.
// Ready depends only on state, counter, enable and mode; scan ignores the select stream.
module decoder_strobe_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int PULSE_LEN  = 1,
  parameter int SCAN_DWELL = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                enable_in,
  input  logic [1:0]          mode_in,
  input  logic                sel_valid_in,
  input  logic [SEL_W-1:0]    sel_in,
  output logic                sel_ready_out,
  output logic [2**SEL_W-1:0] y_out,
  output logic [SEL_W-1:0]    active_idx_out,
  output logic                busy_out
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = cnt_width(PULSE_LEN, SCAN_DWELL);
  localparam logic [CNT_W-1:0] PULSE_RLD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] DWELL_RLD = CNT_W'(SCAN_DWELL - 1);

  state_t             state;
  logic [SEL_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [OUT_W-1:0]   y_reg;

  logic               abort;
  logic               ready_int;
  logic               accept;
  logic               cnt_zero;
  logic               dec_en;
  logic [SEL_W-1:0]   dec_idx;
  logic [OUT_W-1:0]   dec_y;

  assign cnt_zero = (cnt == '0);

  // Abort is a mode that no longer matches the running state, or enable dropped.
  always_comb begin
    abort     = 1'b0;
    ready_int = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_int = enable_in && (mode_in == MODE_LEVEL || mode_in == MODE_PULSE);
      end
      ST_HOLD: begin
        abort     = !enable_in || (mode_in != MODE_LEVEL);
        ready_int = !abort;
      end
      ST_PULSE: begin
        abort     = !enable_in || (mode_in != MODE_PULSE);
        ready_int = !abort && cnt_zero;
      end
      ST_SCAN: begin
        abort     = !enable_in || (mode_in != MODE_SCAN);
        ready_int = 1'b0;
      end
      default: begin
        abort     = 1'b1;
        ready_int = 1'b0;
      end
    endcase
  end

  assign accept        = sel_valid_in && ready_int;
  assign sel_ready_out = rst_n_in && ready_int;

  // Next-cycle line selection, decoded now so y_out is a plain register.
  always_comb begin
    dec_en  = 1'b0;
    dec_idx = idx;
    if (accept) begin
      dec_en  = 1'b1;
      dec_idx = sel_in;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_in && mode_in == MODE_SCAN) begin
            dec_en  = 1'b1;
            dec_idx = '0;
          end
        end
        ST_HOLD:  dec_en = !abort;
        ST_PULSE: dec_en = !abort && !cnt_zero;
        ST_SCAN: begin
          dec_en = !abort;
          if (cnt_zero) dec_idx = idx + SEL_W'(1);
        end
        default:  dec_en = 1'b0;
      endcase
    end
  end

  onehot_decode #(.SEL_W(SEL_W)) u_dec (
    .en  (dec_en),
    .idx (dec_idx),
    .y   (dec_y)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      y_reg <= '0;
    end else begin
      y_reg <= dec_y;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= (mode_in == MODE_LEVEL) ? ST_HOLD : ST_PULSE;
            idx   <= sel_in;
            cnt   <= (mode_in == MODE_PULSE) ? PULSE_RLD : '0;
          end else if (enable_in && mode_in == MODE_SCAN) begin
            state <= ST_SCAN;
            idx   <= '0;
            cnt   <= DWELL_RLD;
          end
        end
        ST_HOLD: begin
          if (abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (accept) begin
            idx <= sel_in;
          end
        end
        ST_PULSE: begin
          if (abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt_zero) begin
            if (accept) begin
              idx <= sel_in;
              cnt <= PULSE_RLD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_SCAN: begin
          if (abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt_zero) begin
            idx <= idx + SEL_W'(1);
            cnt <= DWELL_RLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign y_out          = y_reg ^ {OUT_W{ACTIVE_LOW}};
  assign active_idx_out = idx;
  assign busy_out       = (state != ST_IDLE);

endmodule

// File: doc/decoder_strobe_seq.md
# decoder_strobe_seq

Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with three operating modes: level hold, timed pulse and autonomous scan. It is the sequential successor of the combinational line decoders. It drives chip-select, row-strobe and interrupt-vector lines from a valid/ready select stream or from its own scan counter. The block sits between a control FSM or register file and the decoded fan-out.

## Interface
- SEL_W, 4, select width; OUT_W = 2**SEL_W is a derived localparam.
- PULSE_LEN, 1, active cycles per pulse-mode strobe (>= 1).
- SCAN_DWELL, 4, cycles each line stays active in scan mode (>= 1).
- ACTIVE_LOW, 0, 1 inverts every bit of y_out (idle = all ones).

Ports:
- clk_in  in  1  single clock; all state on the rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- enable_in  in  1  global enable; low forces outputs inactive.
- mode_in  in  2  00 level, 01 pulse, 10 scan, 11 reserved (treated as disabled).
- sel_valid_in  in  1  select request.
- sel_in  in  SEL_W  requested line index.
- sel_ready_out  out  1  select accept; transfer occurs when valid and ready are both high.
- y_out  out  OUT_W  registered one-hot (or one-cold) decoded lines.
- active_idx_out  out  SEL_W  index of the currently driven line.
- busy_out  out  1  high while a line is driven.

## Operation
States: IDLE, HOLD, PULSE, SCAN.
- IDLE: y_out inactive, busy_out 0.
  - Level or pulse mode with enable high: sel_ready_out = 1.
  - On accept, go to HOLD (level) or PULSE (pulse), latching sel_in.
  - Scan mode with enable high: go to SCAN at index 0.
- HOLD: y_out = one-hot(latched index).
  - sel_ready_out = 1. A new accept replaces the index, with no inactive gap.
  - Leaves to IDLE only on enable low or a mode change.
- PULSE: line active for exactly PULSE_LEN cycles, then IDLE.
  - sel_ready_out = 0, except in the final pulse cycle, where it is 1.
  - An accept in the final cycle starts the next pulse back-to-back (restarts the counter, reloads the index).
- SCAN: sel_ready_out = 0 and sel_valid_in is ignored.
  - Index advances every SCAN_DWELL cycles, wrapping OUT_W-1 -> 0.
- Abort: enable_in low, a mode change, or mode 11 forces IDLE on the next edge.
  - y_out goes inactive and the pulse/dwell counter is cleared.
  - No pending select is retained.
- Active polarity: every y_out value is XORed with {OUT_W{ACTIVE_LOW}}.
- Range: there are no out-of-range selects, because OUT_W = 2**SEL_W.
- Counter: one shared counter of width $clog2(max(PULSE_LEN, SCAN_DWELL)+1). It counts down and never wraps below 0.

## Timing
- Reset values:
  - y_out = {OUT_W{ACTIVE_LOW}} (inactive).
  - active_idx_out = 0, busy_out = 0, state IDLE, counter 0.
  - sel_ready_out = 0 while rst_n_in is low.
- Latency: accept at edge N; y_out, active_idx_out and busy_out update at edge N+1 (1 cycle).
- sel_ready_out is combinational from state, counter, enable_in and mode_in. It has no path from sel_valid_in.
- Pulse width is exactly PULSE_LEN cycles. Back-to-back pulses leave zero inactive cycles between them.
- Scan: each index is held exactly SCAN_DWELL cycles. The first index, 0, appears 1 cycle after scan becomes legal.
- Reset asserted mid-pulse or mid-scan clears outputs immediately (asynchronously). After deassertion the block restarts from IDLE.
- Simultaneous abort and accept: abort wins, and the select is not consumed.

## Structure
- Package decoder_pkg holds:
  - the state enum,
  - MODE_LEVEL/MODE_PULSE/MODE_SCAN/MODE_RSVD constants,
  - a onehot function.
- Sub-module onehot_decode (SEL_W parameter; enable, index -> OUT_W one-hot) is instantiated once. Its output is registered in this block before the polarity XOR.

## Test plan
Bench parameters: SEL_W=3, PULSE_LEN=2, SCAN_DWELL=3, ACTIVE_LOW=0.
- Reset and level accept: reset, then level mode, enable=1, accept sel=5 -> y_out=8'h20 one cycle later; held 10 cycles; busy_out=1.
- Level reselect: in HOLD, accept sel=2 -> y_out goes 8'h20 -> 8'h04 on the next edge with no zero cycle.
- Pulse back-to-back: pulse mode, accept sel=1, then sel=6 in the final cycle -> y_out = 02, 02, 40, 40, 00; ready = 1, 0, 1, 0, 1.
- Scan wrap: scan mode for 27 cycles -> indices 0..7, each held 3 cycles, wrapping to 0; sel_valid_in is ignored and ready stays 0.
- Abort: enable low mid-pulse -> y_out=0 next edge and busy_out=0. Same-cycle accept is not consumed. Mode 11 behaves identically.
- Async reset and polarity: reset pulse mid-scan -> y_out inactive without a clock edge. Repeat with ACTIVE_LOW=1 -> idle 8'hFF, sel=3 -> 8'hF7.
